// File: rtl/dc_sweep_pkg.sv
// dc_sweep_pkg: shared widths, sequencer state encoding and the tagged result record
package dc_sweep_pkg;
  localparam int DAC_W = 12;
  localparam int ADC_W = 16;
  localparam int IDX_W = 8;
  localparam int SET_W = 16;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CONV, EMIT, NEXT} sweep_state_t;
  typedef struct packed {
    logic [IDX_W-1:0] gi;
    logic [IDX_W-1:0] di;
    logic [ADC_W-1:0] id;
    logic             clip;
  } result_t;
endpackage

// File: rtl/dc_sweep_sequencer_if.sv
// dc_sweep_sequencer_if: DAC load, ADC req/ack and result valid/ready bundle
// master = sequencer (drives DAC codes, adc_req, result stream), slave = DAC/ADC/capture side
interface dc_sweep_sequencer_if;
  import dc_sweep_pkg::*;
  logic [DAC_W-1:0] dac_vgs;
  logic [DAC_W-1:0] dac_vds;
  logic             dac_load;
  logic             adc_req;
  logic             adc_ack;
  logic [ADC_W-1:0] adc_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_gi;
  logic [IDX_W-1:0] out_di;
  logic [ADC_W-1:0] out_id;
  logic             out_clip;
  modport master (
    output dac_vgs, dac_vds, dac_load, adc_req, out_valid, out_gi, out_di, out_id, out_clip,
    input  adc_ack, adc_data, out_ready
  );
  modport slave (
    input  dac_vgs, dac_vds, dac_load, adc_req, out_valid, out_gi, out_di, out_id, out_clip,
    output adc_ack, adc_data, out_ready
  );
endinterface

// File: rtl/sweep_axis_counter.sv
// sweep_axis_counter: one sweep axis, point index plus saturating DAC code
// load captures start/step/npts and rewinds; rewind restarts the axis; step_en advances one point
// last flags the final point (npts=0 counts as 1); clip flags a saturated code
module sweep_axis_counter #(
  parameter int DAC_W = 12,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             rewind,
  input  logic             step_en,
  input  logic [DAC_W-1:0] start_code,
  input  logic [DAC_W-1:0] step,
  input  logic [IDX_W-1:0] npts,
  output logic [IDX_W-1:0] idx,
  output logic [DAC_W-1:0] code,
  output logic             last,
  output logic             clip
);
  logic [DAC_W-1:0] base, inc;
  logic [IDX_W-1:0] n;
  logic [DAC_W:0]   sum;
  assign sum  = {1'b0, code} + {1'b0, inc};
  assign last = ({1'b0, idx} + (IDX_W+1)'(1)) >= {1'b0, n};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      inc  <= '0;
      n    <= '0;
      idx  <= '0;
      code <= '0;
      clip <= 1'b0;
    end else if (load) begin
      base <= start_code;
      inc  <= step;
      n    <= npts;
      idx  <= '0;
      code <= start_code;
      clip <= 1'b0;
    end else if (rewind) begin
      idx  <= '0;
      code <= base;
      clip <= 1'b0;
    end else if (step_en) begin
      idx  <= idx + IDX_W'(1);
      code <= (clip || sum[DAC_W]) ? '1 : sum[DAC_W-1:0];
      clip <= clip || sum[DAC_W];
    end
endmodule

// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer: two-level Vgs/Vds bias sweep with settle, ADC conversion and tagged results
// clk/rst_n: clock, async active-low reset; start/abort: sweep control pulses
// vgs_*/vds_*/settle_cycles: sweep config, sampled on start; busy/done: sweep status
// bus: DAC codes + load strobe, ADC req/ack, result valid/ready stream
module dc_sweep_sequencer
  import dc_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DAC_W-1:0] vgs_start,
  input  logic [DAC_W-1:0] vgs_step,
  input  logic [IDX_W-1:0] vgs_npts,
  input  logic [DAC_W-1:0] vds_start,
  input  logic [DAC_W-1:0] vds_step,
  input  logic [IDX_W-1:0] vds_npts,
  input  logic [SET_W-1:0] settle_cycles,
  output logic             busy,
  output logic             done,
  dc_sweep_sequencer_if.master bus
);
  sweep_state_t     state;
  logic [SET_W-1:0] settle, cnt;
  logic [IDX_W-1:0] gi, di;
  logic [DAC_W-1:0] vgs_code, vds_code;
  logic             vgs_last, vds_last, vgs_clip, vds_clip, cfg_ld, adv;
  assign cfg_ld      = state == IDLE && start && !abort;
  assign adv         = state == NEXT && !abort;
  assign bus.dac_vgs = vgs_code;
  assign bus.dac_vds = vds_code;
  sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_vgs (
    .clk(clk), .rst_n(rst_n), .load(cfg_ld), .rewind(1'b0),
    .step_en(adv && vds_last && !vgs_last),
    .start_code(vgs_start), .step(vgs_step), .npts(vgs_npts),
    .idx(gi), .code(vgs_code), .last(vgs_last), .clip(vgs_clip)
  );
  // inner axis rewinds exactly when the outer axis steps
  sweep_axis_counter #(.DAC_W(DAC_W), .IDX_W(IDX_W)) u_vds (
    .clk(clk), .rst_n(rst_n), .load(cfg_ld),
    .rewind(adv && vds_last && !vgs_last), .step_en(adv && !vds_last),
    .start_code(vds_start), .step(vds_step), .npts(vds_npts),
    .idx(di), .code(vds_code), .last(vds_last), .clip(vds_clip)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      settle        <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.dac_load  <= 1'b0;
      bus.adc_req   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_gi    <= '0;
      bus.out_di    <= '0;
      bus.out_id    <= '0;
      bus.out_clip  <= 1'b0;
    end else begin
      bus.dac_load <= 1'b0;
      done         <= 1'b0;
      if (abort && state != IDLE) begin
        state         <= IDLE;
        busy          <= 1'b0;
        bus.adc_req   <= 1'b0;
        bus.out_valid <= 1'b0;
      end else
        case (state)
          IDLE:
            if (start && !abort) begin
              settle       <= settle_cycles;
              busy         <= 1'b1;
              bus.dac_load <= 1'b1;
              state        <= LOAD;
            end
          // zero settle skips SETTLE so adc_req follows dac_load directly
          LOAD:
            if (settle == '0) begin
              bus.adc_req <= 1'b1;
              state       <= CONV;
            end else begin
              cnt   <= settle - SET_W'(1);
              state <= SETTLE;
            end
          SETTLE:
            if (cnt == '0) begin
              bus.adc_req <= 1'b1;
              state       <= CONV;
            end else
              cnt <= cnt - SET_W'(1);
          CONV:
            if (bus.adc_ack) begin
              bus.adc_req   <= 1'b0;
              bus.out_valid <= 1'b1;
              bus.out_gi    <= gi;
              bus.out_di    <= di;
              bus.out_id    <= bus.adc_data;
              bus.out_clip  <= vgs_clip || vds_clip;
              state         <= EMIT;
            end
          EMIT:
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              state         <= NEXT;
            end
          NEXT:
            if (vds_last && vgs_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bus.dac_load <= 1'b1;
              state        <= LOAD;
            end
          default: state <= IDLE;
        endcase
    end
endmodule
